// File: rtl/func_unit.sv
// Register-file function unit: single-cycle ALU/shift ops and a shift-add
// multiply, with a START/BUSY/DONE handshake for the control sequencer.
module func_unit #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       FS,
  input  logic             START,
  output logic [WIDTH-1:0] F,
  output logic             V,
  output logic             C,
  output logic             N,
  output logic             Z,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   f_q, f_d;
  logic               v_q, v_d;
  logic               c_q, c_d;
  logic               n_q, n_d;
  logic               z_q, z_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mult_q, mult_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0]   y;
  logic               cin;
  logic               arith;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_f;
  logic               alu_c;
  logic               alu_v;
  logic [2*WIDTH-1:0] acc_nxt;

  always_comb begin
    y     = '0;
    cin   = 1'b0;
    arith = 1'b0;
    alu_f = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    unique case (FS)
      4'b0000: arith = 1'b1;
      4'b0001: begin arith = 1'b1; cin = 1'b1; end
      4'b0010: begin arith = 1'b1; y = B; end
      4'b0011: begin arith = 1'b1; y = B; cin = 1'b1; end
      4'b0100: begin arith = 1'b1; y = ~B; end
      4'b0101: begin arith = 1'b1; y = ~B; cin = 1'b1; end
      4'b0110: begin arith = 1'b1; y = '1; end
      4'b0111: arith = 1'b1;
      4'b1000: alu_f = A & B;
      4'b1001: alu_f = A | B;
      4'b1010: alu_f = A ^ B;
      4'b1011: alu_f = ~A;
      4'b1100: alu_f = B;
      4'b1101: begin
        alu_f = {1'b0, B[MSB:1]};
        alu_c = B[0];
      end
      4'b1110: begin
        alu_f = {B[MSB-1:0], 1'b0};
        alu_c = B[MSB];
      end
      4'b1111: alu_f = '0;
      default: alu_f = '0;
    endcase
    sum = {1'b0, A} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    if (arith) begin
      alu_f = sum[WIDTH-1:0];
      alu_c = sum[WIDTH];
      alu_v = (A[MSB] == y[MSB]) & (alu_f[MSB] != A[MSB]);
    end
  end

  assign acc_nxt = mult_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    v_d     = v_q;
    c_d     = c_q;
    n_d     = n_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    acc_d   = acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          if (FS == 4'b1111) begin
            mcand_d = {{WIDTH{1'b0}}, A};
            mult_d  = B;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_MUL;
          end else begin
            f_d     = alu_f;
            v_d     = alu_v;
            c_d     = alu_c;
            n_d     = alu_f[MSB];
            z_d     = (alu_f == '0);
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d   = acc_nxt;
        mcand_d = mcand_q << 1;
        mult_d  = mult_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        // last iteration's sum goes straight into F
        if (cnt_q == LAST) begin
          f_d     = acc_nxt[WIDTH-1:0];
          v_d     = 1'b0;
          c_d     = |acc_nxt[2*WIDTH-1:WIDTH];
          n_d     = acc_nxt[MSB];
          z_d     = (acc_nxt[WIDTH-1:0] == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      f_q     <= '0;
      v_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      mult_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      v_q     <= v_d;
      c_q     <= c_d;
      n_q     <= n_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      acc_q   <= acc_d;
    end
  end

  assign F    = f_q;
  assign V    = v_q;
  assign C    = c_q;
  assign N    = n_q;
  assign Z    = z_q;
  assign BUSY = (state_q != S_IDLE);
  assign DONE = (state_q == S_DONE);

endmodule

// File: tb/tb_func_unit.sv
// Directed testbench for func_unit: ALU ops, shifts, multiply timing,
// START masking while busy and asynchronous reset abort.
module tb_func_unit;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  fs;
  logic        start;
  logic [15:0] f;
  logic        v, c, n, z;
  logic        busy, done;

  int nvec = 0;
  int nerr = 0;

  func_unit #(.WIDTH(16)) dut (
    .CLK(clk), .RESET(rst), .A(a), .B(b), .FS(fs), .START(start),
    .F(f), .V(v), .C(c), .N(n), .Z(z), .BUSY(busy), .DONE(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(input logic [3:0] op, input logic [15:0] av,
                        input logic [15:0] bv, output int lat,
                        output int bcnt);
    @(negedge clk);
    fs = op; a = av; b = bv; start = 1'b1;
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) bcnt++;
    end while (!done && lat < 40);
    @(negedge clk);
  endtask

  task automatic test_reset;
    #3 rst = 1'b0;
    #1;
    nvec++;
    if ({f, v, c, n, z, busy, done} !== 22'd0) begin
      nerr++;
      $display("FAIL reset: F=%h VCNZ=%b%b%b%b BUSY=%b DONE=%b, want all 0",
               f, v, c, n, z, busy, done);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_add;
    int lat, bc;
    run_op(4'b0010, 16'h7FFF, 16'h0001, lat, bc);
    nvec++;
    if (lat !== 1) begin
      nerr++; $display("FAIL add_lat: got %0d want 1", lat);
    end
    nvec++;
    if ({f, v, c, n, z} !== {16'h8000, 4'b1010}) begin
      nerr++; $display("FAIL add_ovf: F=%h VCNZ=%b%b%b%b want 8000 1010",
                       f, v, c, n, z);
    end
    run_op(4'b0010, 16'h8000, 16'h8000, lat, bc);
    nvec++;
    if ({f, v, c, n, z} !== {16'h0000, 4'b1101}) begin
      nerr++; $display("FAIL add_negovf: F=%h VCNZ=%b%b%b%b want 0000 1101",
                       f, v, c, n, z);
    end
  endtask

  task automatic test_sub;
    int lat, bc;
    run_op(4'b0101, 16'h0005, 16'h0005, lat, bc);
    nvec++;
    if ({f, v, c, n, z} !== {16'h0000, 4'b0101}) begin
      nerr++; $display("FAIL sub: F=%h VCNZ=%b%b%b%b want 0000 0101",
                       f, v, c, n, z);
    end
    run_op(4'b0110, 16'h0000, 16'h1234, lat, bc);
    nvec++;
    if ({f, v, c, n, z} !== {16'hFFFF, 4'b0010}) begin
      nerr++; $display("FAIL dec: F=%h VCNZ=%b%b%b%b want FFFF 0010",
                       f, v, c, n, z);
    end
  endtask

  task automatic test_logic;
    logic [3:0]  ops [6] = '{4'b1000, 4'b1001, 4'b1010, 4'b1011,
                             4'b1100, 4'b0001};
    logic [15:0] av  [6] = '{16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0,
                             16'hF0F0, 16'hFFFF};
    logic [15:0] exf [6] = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0F0F,
                             16'hFF00, 16'h0000};
    logic [3:0]  exl [6] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000,
                             4'b0010, 4'b0101};
    int lat, bc;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], av[i], 16'hFF00, lat, bc);
      nvec++;
      if ({f, v, c, n, z} !== {exf[i], exl[i]}) begin
        nerr++;
        $display("FAIL logic[%0d] fs=%b: F=%h VCNZ=%b%b%b%b want %h %b",
                 i, ops[i], f, v, c, n, z, exf[i], exl[i]);
      end
    end
  endtask

  task automatic test_shift;
    int lat, bc;
    run_op(4'b1110, 16'h5555, 16'h8001, lat, bc);
    nvec++;
    if ({f, v, c, n, z} !== {16'h0002, 4'b0100}) begin
      nerr++; $display("FAIL shl: F=%h VCNZ=%b%b%b%b want 0002 0100",
                       f, v, c, n, z);
    end
    run_op(4'b1101, 16'h5555, 16'h8001, lat, bc);
    nvec++;
    if ({f, v, c, n, z} !== {16'h4000, 4'b0100}) begin
      nerr++; $display("FAIL shr: F=%h VCNZ=%b%b%b%b want 4000 0100",
                       f, v, c, n, z);
    end
  endtask

  task automatic test_mul;
    int lat, bc;
    logic [15:0] fprev;
    logic changed;
    fprev = f;
    changed = 1'b0;
    @(negedge clk);
    fs = 4'b1111; a = 16'h00FF; b = 16'h0003; start = 1'b1;
    lat = 0; bc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) bc++;
      if (!done && f !== fprev) changed = 1'b1;
      if (lat == 3) begin a = 16'hAAAA; b = 16'h5555; end
      if (lat == 5) begin
        start = 1'b1; fs = 4'b0000; a = 16'h1234;
      end
    end while (!done && lat < 40);
    nvec++;
    if (lat !== 17) begin
      nerr++; $display("FAIL mul_lat: got %0d want 17", lat);
    end
    nvec++;
    if (bc !== 17) begin
      nerr++; $display("FAIL mul_busy: got %0d want 17", bc);
    end
    nvec++;
    if (changed !== 1'b0) begin
      nerr++; $display("FAIL mul_hold: F changed before DONE, want %h", fprev);
    end
    nvec++;
    if ({f, v, c, n, z} !== {16'h02FD, 4'b0000}) begin
      nerr++; $display("FAIL mul: F=%h VCNZ=%b%b%b%b want 02FD 0000",
                       f, v, c, n, z);
    end
    @(negedge clk);
    nvec++;
    if (busy !== 1'b0 || f !== 16'h02FD) begin
      nerr++; $display("FAIL mul_ignore: BUSY=%b F=%h want 0 02FD", busy, f);
    end
  endtask

  task automatic test_mul_ovf;
    int lat, bc;
    run_op(4'b1111, 16'h0100, 16'h0100, lat, bc);
    nvec++;
    if ({f, v, c, n, z} !== {16'h0000, 4'b0101} || lat !== 17) begin
      nerr++; $display("FAIL mul_ovf: F=%h VCNZ=%b%b%b%b lat=%0d want 0000 0101 17",
                       f, v, c, n, z, lat);
    end
  endtask

  task automatic test_reset_mid_mul;
    int lat, bc, ndone;
    run_op(4'b0010, 16'h0001, 16'h0001, lat, bc);
    @(negedge clk);
    fs = 4'b1111; a = 16'h0123; b = 16'hFFFF; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    nvec++;
    if ({f, v, c, n, z, busy, done} !== 22'd0) begin
      nerr++;
      $display("FAIL mid_reset: F=%h VCNZ=%b%b%b%b BUSY=%b DONE=%b want all 0",
               f, v, c, n, z, busy, done);
    end
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    nvec++;
    if (ndone !== 0) begin
      nerr++; $display("FAIL no_done: saw %0d DONE cycles want 0", ndone);
    end
    run_op(4'b0010, 16'h0003, 16'h0004, lat, bc);
    nvec++;
    if ({f, v, c, n, z} !== {16'h0007, 4'b0000} || lat !== 1) begin
      nerr++; $display("FAIL post_reset_add: F=%h VCNZ=%b%b%b%b lat=%0d want 0007 0000 1",
                       f, v, c, n, z, lat);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fs = 4'd0; a = 16'd0; b = 16'd0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_mul();
    test_mul_ovf();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
